// File: rtl/multicycle_control.sv
// Moore sequencer for a multicycle RV32I datapath (unified memory, IR, ALUOut, shared ALU).
// Optional performance counters are enabled by defining MC_PERF_CNT_EN.
module multicycle_control #(
    parameter int WAIT_LIMIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        pc_source,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [3:0]  state_out,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_TRAP      = 4'd15
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam logic [31:0] WAIT_LAST = 32'(WAIT_LIMIT - 1);

    state_t      state_q, state_d;
    logic [31:0] wait_q, wait_d;
    logic [1:0]  cause_q, cause_d;

    logic        mem_state;
    logic        timeout;
    logic        pc_write_c, pc_write_cond_c;
    logic        iord_c, mem_read_c, mem_write_c, ir_write_c;
    logic        mem_to_reg_c, reg_write_c, pc_source_c;
    logic [1:0]  alu_src_a_c, alu_src_b_c, alu_op_c;

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                       (state_q == S_MEM_WRITE);
    // Timeout fires on the cycle the counter would reach WAIT_LIMIT, so exactly
    // WAIT_LIMIT unanswered cycles are tolerated before trapping.
    assign timeout = (WAIT_LIMIT != 0) && mem_state && !mem_ready && (wait_q == WAIT_LAST);

    always_comb begin
        state_d         = state_q;
        cause_d         = cause_q;
        pc_write_c      = 1'b0;
        pc_write_cond_c = 1'b0;
        iord_c          = 1'b0;
        mem_read_c      = 1'b0;
        mem_write_c     = 1'b0;
        ir_write_c      = 1'b0;
        mem_to_reg_c    = 1'b0;
        reg_write_c     = 1'b0;
        pc_source_c     = 1'b0;
        alu_src_a_c     = 2'b00;
        alu_src_b_c     = 2'b00;
        alu_op_c        = 2'b00;

        case (state_q)
            S_FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = 2'b01;
                if (timeout) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                alu_src_b_c = 2'b10;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_R:         state_d = S_EXEC_R;
                    OP_I:         state_d = S_EXEC_I;
                    OP_BEQ:       state_d = S_BRANCH;
                    default: begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b10;
                state_d     = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_read_c = 1'b1;
                iord_c     = 1'b1;
                if (timeout) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else if (mem_ready) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write_c = 1'b1;
                iord_c      = 1'b1;
                if (timeout) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_src_a_c = 2'b01;
                alu_op_c    = 2'b10;
                state_d     = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b10;
                alu_op_c    = 2'b11;
                state_d     = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_c     = 2'b01;
                alu_op_c        = 2'b01;
                pc_write_cond_c = 1'b1;
                pc_source_c     = 1'b1;
                state_d         = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase

        if ((state_d == state_q) && mem_state && !mem_ready) begin
            wait_d = wait_q + 32'd1;
        end else begin
            wait_d = 32'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            wait_q  <= 32'd0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
        end
    end

    // Requests and enables are forced low while rst is held so an aborted
    // access cannot complete; mux selects still show the FETCH values.
    assign pc_en      = !rst && (pc_write_c || (pc_write_cond_c && zero));
    assign mem_read   = !rst && mem_read_c;
    assign mem_write  = !rst && mem_write_c;
    assign ir_write   = !rst && ir_write_c;
    assign reg_write  = !rst && reg_write_c;
    assign iord       = iord_c;
    assign mem_to_reg = mem_to_reg_c;
    assign alu_src_a  = alu_src_a_c;
    assign alu_src_b  = alu_src_b_c;
    assign alu_op     = alu_op_c;
    assign pc_source  = pc_source_c;
    assign trap       = (state_q == S_TRAP);
    assign trap_cause = cause_q;
    assign state_out  = state_q;

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] instr_q, instr_d;
    logic        retire;

    // An instruction retires on the edge that returns the sequencer to FETCH.
    assign retire = (state_d == S_FETCH) &&
                    ((state_q == S_MEM_WB) || (state_q == S_MEM_WRITE) ||
                     (state_q == S_ALU_WB) || (state_q == S_BRANCH));

    always_comb begin
        cycle_d = cycle_q;
        instr_d = instr_q;
        if (state_q != S_TRAP) begin
            cycle_d = cycle_q + 32'd1;
        end
        if (retire) begin
            instr_d = instr_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q <= 32'd0;
            instr_q <= 32'd0;
        end else begin
            cycle_q <= cycle_d;
            instr_q <= instr_d;
        end
    end

    assign cycle_count = cycle_q;
    assign instr_count = instr_q;
`else
    assign cycle_count = 32'd0;
    assign instr_count = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control (WAIT_LIMIT=5); counter checks follow MC_PERF_CNT_EN.
module tb_multicycle_control;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic        clk;
    logic        rst;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, alu_op;
    logic        pc_source, trap;
    logic [1:0]  trap_cause;
    logic [3:0]  state_out;
    logic [31:0] cycle_count, instr_count;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_control #(.WAIT_LIMIT(5)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .trap(trap), .trap_cause(trap_cause),
        .state_out(state_out), .cycle_count(cycle_count), .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        rst = 1'b0; opcode = OP_R; zero = 1'b0; mem_ready = 1'b1;
        #1 rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        n_checks++; if (state_out !== 4'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state_out); end
        n_checks++; if (trap !== 1'b0 || trap_cause !== 2'b00) begin n_fail++; $display("FAIL reset_trap got %b/%b want 0/00", trap, trap_cause); end
        n_checks++; if (alu_src_b !== 2'b01) begin n_fail++; $display("FAIL reset_srcb got %b want 01", alu_src_b); end
        n_checks++; if (pc_en !== 1'b0 || mem_write !== 1'b0 || reg_write !== 1'b0 || ir_write !== 1'b0) begin
            n_fail++; $display("FAIL reset_enables got pc_en=%b mw=%b rw=%b irw=%b want 0", pc_en, mem_write, reg_write, ir_write); end
        n_checks++; if (cycle_count !== 32'd0 || instr_count !== 32'd0) begin n_fail++; $display("FAIL reset_counts got %0d/%0d want 0/0", cycle_count, instr_count); end
        rst = 1'b0;
    endtask

    task automatic test_r_type;
        logic [3:0] exp_s [4];
        exp_s = '{4'd1, 4'd6, 4'd8, 4'd0};
        opcode = OP_R; mem_ready = 1'b1;
        #1;
        n_checks++; if (state_out !== 4'd0 || pc_en !== 1'b1 || ir_write !== 1'b1 || mem_read !== 1'b1) begin
            n_fail++; $display("FAIL r_fetch got s=%0d pc_en=%b irw=%b mr=%b want 0/1/1/1", state_out, pc_en, ir_write, mem_read); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_checks++; if (state_out !== exp_s[i]) begin n_fail++; $display("FAIL r_state[%0d] got %0d want %0d", i, state_out, exp_s[i]); end
            n_checks++; if (reg_write !== (exp_s[i] == 4'd8) || pc_en !== (exp_s[i] == 4'd0)) begin
                n_fail++; $display("FAIL r_en[%0d] got rw=%b pc_en=%b want %b/%b", i, reg_write, pc_en, exp_s[i] == 4'd8, exp_s[i] == 4'd0); end
            if (exp_s[i] == 4'd6) begin
                n_checks++; if (alu_op !== 2'b10 || alu_src_a !== 2'b01 || alu_src_b !== 2'b00) begin
                    n_fail++; $display("FAIL r_exec_sel got op=%b a=%b b=%b want 10/01/00", alu_op, alu_src_a, alu_src_b); end
            end
        end
    endtask

    task automatic test_lw_wait;
        logic [3:0] exp_s [8];
        logic       rdy   [8];
        exp_s = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
        rdy   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        opcode = OP_LW; mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            n_checks++; if (state_out !== exp_s[i]) begin n_fail++; $display("FAIL lw_state[%0d] got %0d want %0d", i, state_out, exp_s[i]); end
            if (exp_s[i] == 4'd3) begin
                n_checks++; if (mem_read !== 1'b1 || iord !== 1'b1 || mem_write !== 1'b0) begin
                    n_fail++; $display("FAIL lw_req[%0d] got mr=%b iord=%b mw=%b want 1/1/0", i, mem_read, iord, mem_write); end
            end
            if (exp_s[i] == 4'd4) begin
                n_checks++; if (reg_write !== 1'b1 || mem_to_reg !== 1'b1) begin
                    n_fail++; $display("FAIL lw_wb got rw=%b m2r=%b want 1/1", reg_write, mem_to_reg); end
            end
            mem_ready = rdy[i];
        end
    endtask

    task automatic test_branch;
        logic [3:0] exp_s [3];
        exp_s = '{4'd1, 4'd9, 4'd0};
        opcode = OP_BEQ; mem_ready = 1'b1;
        for (int z = 1; z >= 0; z--) begin
            zero = (z == 1);
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                n_checks++; if (state_out !== exp_s[i]) begin n_fail++; $display("FAIL beq%0d_state[%0d] got %0d want %0d", z, i, state_out, exp_s[i]); end
                if (exp_s[i] == 4'd9) begin
                    n_checks++; if (pc_en !== zero || pc_source !== 1'b1 || alu_op !== 2'b01) begin
                        n_fail++; $display("FAIL beq%0d_out got pc_en=%b src=%b op=%b want %b/1/01", z, pc_en, pc_source, alu_op, zero); end
                end
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_illegal;
        opcode = OP_BAD; mem_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (state_out !== 4'd1) begin n_fail++; $display("FAIL ill_decode got %0d want 1", state_out); end
        @(posedge clk); #1;
        n_checks++; if (state_out !== 4'd15 || trap !== 1'b1 || trap_cause !== 2'b01) begin
            n_fail++; $display("FAIL ill_trap got s=%0d trap=%b cause=%b want 15/1/01", state_out, trap, trap_cause); end
        repeat (20) @(posedge clk);
        #1;
        n_checks++; if (state_out !== 4'd15 || trap !== 1'b1 || mem_read !== 1'b0 || pc_en !== 1'b0) begin
            n_fail++; $display("FAIL ill_sticky got s=%0d trap=%b mr=%b pc_en=%b want 15/1/0/0", state_out, trap, mem_read, pc_en); end
        rst = 1'b1; #1;
        n_checks++; if (state_out !== 4'd0 || trap !== 1'b0 || trap_cause !== 2'b00) begin
            n_fail++; $display("FAIL ill_reset got s=%0d trap=%b cause=%b want 0/0/00", state_out, trap, trap_cause); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_timeout;
        mem_ready = 1'b0; opcode = OP_R;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (state_out !== 4'd0 || ir_write !== 1'b0 || mem_read !== 1'b1) begin
                n_fail++; $display("FAIL to_wait[%0d] got s=%0d irw=%b mr=%b want 0/0/1", i, state_out, ir_write, mem_read); end
            @(posedge clk);
        end
        #1;
        n_checks++; if (state_out !== 4'd15 || trap !== 1'b1 || trap_cause !== 2'b10 || ir_write !== 1'b0) begin
            n_fail++; $display("FAIL to_trap got s=%0d trap=%b cause=%b irw=%b want 15/1/10/0", state_out, trap, trap_cause, ir_write); end
    endtask

    task automatic test_perf_counters;
        logic [31:0] exp_c, exp_i;
`ifdef MC_PERF_CNT_EN
        exp_c = 32'd21; exp_i = 32'd5;
`else
        exp_c = 32'd0;  exp_i = 32'd0;
`endif
        mem_ready = 1'b1; opcode = OP_R;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (16) @(posedge clk);
        #1 opcode = OP_LW;
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (state_out !== 4'd0) begin n_fail++; $display("FAIL perf_state got %0d want 0", state_out); end
        n_checks++; if (instr_count !== exp_i) begin n_fail++; $display("FAIL perf_instr got %0d want %0d", instr_count, exp_i); end
        n_checks++; if (cycle_count !== exp_c) begin n_fail++; $display("FAIL perf_cycle got %0d want %0d", cycle_count, exp_c); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_checks++; if (instr_count !== 32'd0 || cycle_count !== 32'd0 || state_out !== 4'd0) begin
            n_fail++; $display("FAIL perf_clear got i=%0d c=%0d s=%0d want 0/0/0", instr_count, cycle_count, state_out); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_lw_wait();
        test_branch();
        test_illegal();
        test_timeout();
        test_perf_counters();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
